// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result bundle for serial_magnitude_comparator.
// master drives a request, slave (the comparator) returns status and result flags.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             greater;
    logic             less;
    logic             equal;

    modport master (
        output start, signed_mode, x, y,
        input  busy, done, greater, less, equal
    );

    modport slave (
        input  start, signed_mode, x, y,
        output busy, done, greater, less, equal
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, unsigned or two's complement.
// Optional macro COMP_EARLY_TERM_EN: finish at the first differing digit instead of after all N digits.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    serial_magnitude_comparator_if.slave   bus,
    output logic [1:0]                     state_dbg
);
    // Handshake: start is sampled only in IDLE or DONE (x, y, signed_mode captured with it);
    // busy is high for every RUN cycle; done is a one-cycle pulse in DONE, when
    // greater/less/equal become valid. They then hold until the next done.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             gt;
    logic             lt;
    logic             busy_q;
    logic             done_q;
    logic             greater_q;
    logic             less_q;
    logic             equal_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             undecided;
    logic             gt_nxt;
    logic             lt_nxt;
    logic             last;
    logic             finish;
    logic [WIDTH-1:0] sign_flip;

    always_comb begin
        a_dig     = a_sr[WIDTH-1 -: DIGIT];
        b_dig     = b_sr[WIDTH-1 -: DIGIT];
        undecided = !(gt | lt);
        gt_nxt    = gt | (undecided & (a_dig > b_dig));
        lt_nxt    = lt | (undecided & (a_dig < b_dig));
        last      = (cnt == CW'(N - 1));
`ifdef COMP_EARLY_TERM_EN
        finish    = last | (undecided & (a_dig != b_dig));
`else
        finish    = last;
`endif
        // Offset-binary: flipping both MSBs turns a signed compare into an unsigned one.
        sign_flip = bus.signed_mode ? MSB_MASK : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            cnt       <= '0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.x ^ sign_flip;
                        b_sr   <= bus.y ^ sign_flip;
                        cnt    <= '0;
                        gt     <= 1'b0;
                        lt     <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    gt   <= gt_nxt;
                    lt   <= lt_nxt;
                    a_sr <= a_sr << DIGIT;
                    b_sr <= b_sr << DIGIT;
                    cnt  <= cnt + CW'(1);
                    if (finish) begin
                        greater_q <= gt_nxt;
                        less_q    <= lt_nxt;
                        equal_q   <= !(gt_nxt | lt_nxt);
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.greater = greater_q;
    assign bus.less    = less_q;
    assign bus.equal   = equal_q;
    assign state_dbg   = state;
endmodule
